vtg_param_timing_gen: RTL

- Parametrised, runtime-configurable successor to the fixed DMT timing generator.
- Produces hsync/vsync/de plus pixel coordinates, a frame-start pulse and an early data-enable (pre_de) for frame-buffer FIFO prefetch.
- Timing set (active/porch/sync per axis, sync polarity) is reloadable at runtime and takes effect only on a frame boundary.
- Sits between the frame-buffer read path and the HDMI encoder.

---
 rtl/vtg_pkg.sv | 35 +++
 rtl/vtg_delay_line.sv | 39 +++
 rtl/vtg_param_timing_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vtg_pkg.sv
// Shared types and constants for the runtime-configurable video timing generator.
// The timing struct fixes the field width at VTG_CNT_W; instances must use CNT_W = VTG_CNT_W.
package vtg_pkg;

    localparam int VTG_CNT_W = 12;

    localparam int VTG_720P_H_ACTIVE = 1280;
    localparam int VTG_720P_H_FP     = 110;
    localparam int VTG_720P_H_SYNC   = 40;
    localparam int VTG_720P_H_BP     = 220;
    localparam int VTG_720P_V_ACTIVE = 720;
    localparam int VTG_720P_V_FP     = 5;
    localparam int VTG_720P_V_SYNC   = 5;
    localparam int VTG_720P_V_BP     = 20;

    typedef struct packed {
        logic [VTG_CNT_W-1:0] h_active;
        logic [VTG_CNT_W-1:0] h_fp;
        logic [VTG_CNT_W-1:0] h_sync;
        logic [VTG_CNT_W-1:0] h_bp;
        logic [VTG_CNT_W-1:0] v_active;
        logic [VTG_CNT_W-1:0] v_fp;
        logic [VTG_CNT_W-1:0] v_sync;
        logic [VTG_CNT_W-1:0] v_bp;
        logic                 hs_pol;
        logic                 vs_pol;
    } timing_cfg_t;

    // Polarity bits are free; every length field must be nonzero.
    function automatic logic timing_valid(input timing_cfg_t c);
        return (c.h_active != '0) && (c.h_fp != '0) && (c.h_sync != '0) && (c.h_bp != '0) &&
               (c.v_active != '0) && (c.v_fp != '0) && (c.v_sync != '0) && (c.v_bp != '0);
    endfunction

endpackage

// File: rtl/vtg_delay_line.sv
// Fixed-depth shift register with synchronous reset to an idle word.
// DEPTH = 0 degenerates to a combinational pass-through.
module vtg_delay_line #(
    parameter int                WIDTH = 1,
    parameter int                DEPTH = 1,
    parameter logic [WIDTH-1:0]  IDLE  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = clk & rst_n;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                        stage[i] <= IDLE;
                    end
                end else begin
                    stage[0] <= d;
                    for (int unsigned i = 1; i < unsigned'(DEPTH); i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vtg_param_timing_gen.sv
// Runtime-configurable hsync/vsync/de timing generator with pre_de lookahead
// for frame-buffer prefetch; new timing takes effect only on a frame boundary.
module vtg_param_timing_gen
    import vtg_pkg::*;
#(
    parameter int   CNT_W        = VTG_CNT_W,
    parameter int   PREFETCH     = 2,
    parameter int   DEF_H_ACTIVE = VTG_720P_H_ACTIVE,
    parameter int   DEF_H_FP     = VTG_720P_H_FP,
    parameter int   DEF_H_SYNC   = VTG_720P_H_SYNC,
    parameter int   DEF_H_BP     = VTG_720P_H_BP,
    parameter int   DEF_V_ACTIVE = VTG_720P_V_ACTIVE,
    parameter int   DEF_V_FP     = VTG_720P_V_FP,
    parameter int   DEF_V_SYNC   = VTG_720P_V_SYNC,
    parameter int   DEF_V_BP     = VTG_720P_V_BP,
    parameter logic DEF_HS_POL   = 1'b1,
    parameter logic DEF_VS_POL   = 1'b1
) (
    input  logic             pixe_clk,
    input  logic             rest_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    input  logic             cfg_load,
    output logic             cfg_busy,
    output logic             cfg_err,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             pre_de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
);

    localparam int TW     = CNT_W + 2;
    localparam int PIPE_W = 4 + 2 * CNT_W;

    localparam timing_cfg_t DEF_CFG = '{
        h_active: VTG_CNT_W'(DEF_H_ACTIVE),
        h_fp:     VTG_CNT_W'(DEF_H_FP),
        h_sync:   VTG_CNT_W'(DEF_H_SYNC),
        h_bp:     VTG_CNT_W'(DEF_H_BP),
        v_active: VTG_CNT_W'(DEF_V_ACTIVE),
        v_fp:     VTG_CNT_W'(DEF_V_FP),
        v_sync:   VTG_CNT_W'(DEF_V_SYNC),
        v_bp:     VTG_CNT_W'(DEF_V_BP),
        hs_pol:   DEF_HS_POL,
        vs_pol:   DEF_VS_POL
    };

    localparam logic [PIPE_W-1:0] PIPE_IDLE = {1'b0, ~DEF_HS_POL, ~DEF_VS_POL, 1'b0, {(2*CNT_W){1'b0}}};

    timing_cfg_t work_cfg;
    timing_cfg_t shadow_cfg;
    timing_cfg_t cfg_in;
    logic        cfg_in_ok;

    logic [TW-1:0] h_cnt, v_cnt;
    logic [TW-1:0] h_total, v_total;
    logic [TW-1:0] hs_start, hs_end, vs_start, vs_end;
    logic          last_h, last_v, frame_end, cfg_apply;

    logic          de0, hs0_act, vs0_act, fs0;

    logic             s0_de, s0_hs, s0_vs, s0_fs;
    logic [CNT_W-1:0] s0_x, s0_y;
    logic [PIPE_W-1:0] pipe_d, pipe_q;

    assign cfg_in = '{
        h_active: cfg_h_active,
        h_fp:     cfg_h_fp,
        h_sync:   cfg_h_sync,
        h_bp:     cfg_h_bp,
        v_active: cfg_v_active,
        v_fp:     cfg_v_fp,
        v_sync:   cfg_v_sync,
        v_bp:     cfg_v_bp,
        hs_pol:   cfg_hs_pol,
        vs_pol:   cfg_vs_pol
    };

    assign cfg_in_ok = timing_valid(cfg_in);

    always_comb begin
        h_total  = TW'(work_cfg.h_active) + TW'(work_cfg.h_fp) + TW'(work_cfg.h_sync) + TW'(work_cfg.h_bp);
        v_total  = TW'(work_cfg.v_active) + TW'(work_cfg.v_fp) + TW'(work_cfg.v_sync) + TW'(work_cfg.v_bp);
        hs_start = TW'(work_cfg.h_active) + TW'(work_cfg.h_fp);
        hs_end   = hs_start + TW'(work_cfg.h_sync);
        vs_start = TW'(work_cfg.v_active) + TW'(work_cfg.v_fp);
        vs_end   = vs_start + TW'(work_cfg.v_sync);

        last_h    = (h_cnt == h_total - TW'(1));
        last_v    = (v_cnt == v_total - TW'(1));
        frame_end = en && last_h && last_v;
        cfg_apply = frame_end || !en;
    end

    always_ff @(posedge pixe_clk) begin
        if (!rest_n || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (last_h) begin
            h_cnt <= '0;
            v_cnt <= last_v ? '0 : v_cnt + TW'(1);
        end else begin
            h_cnt <= h_cnt + TW'(1);
        end
    end

    // A load on the apply cycle still lands in shadow after the old shadow was applied.
    always_ff @(posedge pixe_clk) begin
        if (!rest_n) begin
            work_cfg   <= DEF_CFG;
            shadow_cfg <= DEF_CFG;
            cfg_busy   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_in_ok;
            if (cfg_apply) begin
                work_cfg <= shadow_cfg;
            end
            if (cfg_load && cfg_in_ok) begin
                shadow_cfg <= cfg_in;
                cfg_busy   <= 1'b1;
            end else if (cfg_apply) begin
                cfg_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        de0     = en && (h_cnt < TW'(work_cfg.h_active)) && (v_cnt < TW'(work_cfg.v_active));
        hs0_act = en && (h_cnt >= hs_start) && (h_cnt < hs_end);
        vs0_act = en && (v_cnt >= vs_start) && (v_cnt < vs_end);
        fs0     = de0 && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge pixe_clk) begin
        if (!rest_n) begin
            s0_de <= 1'b0;
            s0_hs <= ~DEF_HS_POL;
            s0_vs <= ~DEF_VS_POL;
            s0_fs <= 1'b0;
            s0_x  <= '0;
            s0_y  <= '0;
        end else begin
            s0_de <= de0;
            s0_hs <= hs0_act ? work_cfg.hs_pol : ~work_cfg.hs_pol;
            s0_vs <= vs0_act ? work_cfg.vs_pol : ~work_cfg.vs_pol;
            s0_fs <= fs0;
            s0_x  <= de0 ? h_cnt[CNT_W-1:0] : '0;
            s0_y  <= de0 ? v_cnt[CNT_W-1:0] : '0;
        end
    end

    assign pre_de = s0_de;
    assign pipe_d = {s0_de, s0_hs, s0_vs, s0_fs, s0_x, s0_y};

    vtg_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (PREFETCH),
        .IDLE  (PIPE_IDLE)
    ) u_out_pipe (
        .clk   (pixe_clk),
        .rst_n (rest_n),
        .d     (pipe_d),
        .q     (pipe_q)
    );

    assign {de, hsync, vsync, frame_start, x, y} = pipe_q;

endmodule
